// File: rtl/mul_pkg.sv
// Shared encodings and types for the multiply issue controller and its multiplier.
package mul_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] MUL_W   = 3'b001;
    localparam logic [OP_W-1:0] MULH_W  = 3'b010;
    localparam logic [OP_W-1:0] MULH_WU = 3'b100;
    localparam logic [OP_W-1:0] OP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mul_issue_ctrl_mult.sv
// Two-stage 32x32 multiplier: product registered at launch, half selected on the next cycle.
module mul_issue_ctrl_mult
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic [2:0]      op,
    input  logic [31:0]     src1,
    input  logic [31:0]     src2,
    output logic [31:0]     mul_res
);

    localparam int unsigned PROD_W = 2 * XLEN;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_q;
    logic [OP_W-1:0]   op_q;

    // Sign-extending to 64 bits makes the truncated product exact for signed operands.
    always_comb begin
        a_ext = (op == MULH_W) ? {{XLEN{src1[XLEN-1]}}, src1} : {{XLEN{1'b0}}, src1};
        b_ext = (op == MULH_W) ? {{XLEN{src2[XLEN-1]}}, src2} : {{XLEN{1'b0}}, src2};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_q <= '0;
            op_q   <= OP_NONE;
        end else begin
            prod_q <= prod;
            op_q   <= op;
        end
    end

    always_comb begin
        mul_res = '0;
        case (op_q)
            MUL_W:           mul_res = prod_q[XLEN-1:0];
            MULH_W, MULH_WU: mul_res = prod_q[PROD_W-1:XLEN];
            default:         mul_res = '0;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller: accepts EX-stage requests, tracks the in-flight op,
// holds a stalled result until MEM accepts it, and counts completed handshakes.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [4:0]       in_dest,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_dest,
    output logic             busy,
    output logic [4:0]       busy_dest,
    output logic [CNT_W-1:0] done_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [TAG_W-1:0] dest_q;
    logic [XLEN-1:0]  hold_q;
    logic [XLEN-1:0]  mul_res;
    logic [OP_W-1:0]  mul_op;
    logic             accept;
    logic             hold_load;
    logic             handshake;
    logic             op_onehot;

    mul_issue_ctrl_mult u_mult (
        .clk     (clk),
        .resetn  (resetn),
        .op      (mul_op),
        .src1    (in_src1),
        .src2    (in_src2),
        .mul_res (mul_res)
    );

    assign op_onehot = (in_op == MUL_W) || (in_op == MULH_W) || (in_op == MULH_WU);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and multiplier launch.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_result = '0;
        out_dest   = '0;
        hold_load  = 1'b0;
        accept     = 1'b0;
        mul_op     = OP_NONE;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            CALC: begin
                out_valid  = 1'b1;
                out_result = mul_res;
                out_dest   = dest_q;
                in_ready   = out_ready;
                if (out_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                    hold_load = 1'b1;
                end
            end
            HOLD: begin
                out_valid  = 1'b1;
                out_result = hold_q;
                out_dest   = dest_q;
                in_ready   = out_ready;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Flush kills everything; reset only needs to block acceptance here.
        if (flush || !resetn) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            hold_load = 1'b0;
            state_nxt = IDLE;
        end

        accept = in_valid && in_ready;
        if (accept) begin
            state_nxt = CALC;
            mul_op    = op_onehot ? in_op : OP_NONE;
        end
    end

    assign handshake = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign busy_dest = busy ? dest_q : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dest_q   <= '0;
            hold_q   <= '0;
            done_cnt <= '0;
        end else begin
            if (accept) begin
                dest_q <= in_dest;
            end
            if (hold_load) begin
                hold_q <= mul_res;
            end
            if (handshake) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: vector table for single ops plus stall/flush/reset sequences.
module tb_mul_issue_ctrl;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [4:0]  in_dest;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        busy;
    logic [4:0]  busy_dest;
    logic [31:0] done_cnt;

    int n_cmp;
    int n_err;
    int exp_cnt;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    mul_issue_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_dest    (in_dest),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .busy       (busy),
        .busy_dest  (busy_dest),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_dest  = dest;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3'b001, 32'h0000_0003, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFD};
        vecs[1] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000};
        vecs[2] = '{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE};
        vecs[3] = '{3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 32'h0000_0000};
        vecs[4] = '{3'b001, 32'd7,         32'd6,         5'd1,  32'd42};
        vecs[5] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2,  32'hFFFF_FFFF};
        vecs[6] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 5'd3,  32'h0000_0001};
        vecs[7] = '{3'b110, 32'h0000_0005, 32'h0000_0005, 5'd4,  32'h0000_0000};

        n_cmp = 0; n_err = 0; exp_cnt = 0;
        resetn = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_src1 = '0; in_src2 = '0;
        in_dest = '0; flush = 1'b0; out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_cnt", done_cnt, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_busy_dest", 32'(busy_dest), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single ops from the table, each drained immediately.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
            chk("vec_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_result", out_result, vecs[i].exp);
            chk("vec_dest", 32'(out_dest), 32'(vecs[i].dest));
            chk("vec_busy_dest", 32'(busy_dest), 32'(vecs[i].dest));
            tick();
            exp_cnt++;
            chk("vec_idle", 32'(out_valid), 32'd0);
            chk("vec_done_cnt", done_cnt, 32'(exp_cnt));
        end

        // Back-to-back ops at full throughput.
        @(negedge clk);
        drive(3'b001, 32'd2, 32'd3, 5'd1);
        tick();
        drive(3'b001, 32'd4, 32'd5, 5'd2);
        chk("b2b_r1", out_result, 32'd6);
        chk("b2b_d1", 32'(out_dest), 32'd1);
        chk("b2b_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(3'b001, 32'd6, 32'd7, 5'd3);
        chk("b2b_r2", out_result, 32'd20);
        chk("b2b_d2", 32'(out_dest), 32'd2);
        chk("b2b_v2", 32'(out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_r3", out_result, 32'd42);
        chk("b2b_d3", 32'(out_dest), 32'd3);
        chk("b2b_v3", 32'(out_valid), 32'd1);
        tick();
        exp_cnt += 3;
        chk("b2b_idle", 32'(busy), 32'd0);
        chk("b2b_cnt", done_cnt, 32'(exp_cnt));

        // Stall for three cycles; a competing request must wait, then issue on drain.
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'b001, 32'd10, 32'd11, 5'd9);
        tick();
        drive(3'b001, 32'd5, 32'd5, 5'd12);
        chk("hold_calc_r", out_result, 32'd110);
        chk("hold_calc_rdy", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, 32'd110);
            chk("hold_dest", 32'(out_dest), 32'd9);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy_dest", 32'(busy_dest), 32'd9);
        end
        chk("hold_cnt", done_cnt, 32'(exp_cnt));
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        exp_cnt++;
        chk("drain_cnt", done_cnt, 32'(exp_cnt));
        chk("drain_new_r", out_result, 32'd25);
        chk("drain_new_d", 32'(out_dest), 32'd12);
        tick();
        exp_cnt++;
        chk("drain_idle_cnt", done_cnt, 32'(exp_cnt));

        // Flush while in CALC with a new request pending.
        @(negedge clk);
        drive(3'b001, 32'd3, 32'd3, 5'd4);
        tick();
        flush = 1'b1;
        drive(3'b001, 32'd8, 32'd8, 5'd6);
        #1;
        chk("fl_calc_valid", 32'(out_valid), 32'd0);
        chk("fl_calc_rdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_calc_busy", 32'(busy), 32'd0);
        chk("fl_calc_valid2", 32'(out_valid), 32'd0);
        chk("fl_calc_cnt", done_cnt, 32'(exp_cnt));
        tick();
        chk("fl_calc_noacc", 32'(out_valid), 32'd0);

        // Flush while in HOLD with a new request pending.
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'b100, 32'd3, 32'd3, 5'd8);
        tick();
        in_valid = 1'b0;
        tick();
        chk("fl_hold_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(3'b001, 32'd9, 32'd9, 5'd11);
        #1;
        chk("fl_hold_valid", 32'(out_valid), 32'd0);
        chk("fl_hold_rdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_hold_busy", 32'(busy), 32'd0);
        chk("fl_hold_cnt", done_cnt, 32'(exp_cnt));

        // Asynchronous reset while holding a result.
        @(negedge clk);
        out_ready = 1'b0;
        drive(3'b001, 32'd12, 32'd12, 5'd13);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cnt", done_cnt, 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        chk("ar_result", out_result, 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        resetn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive(3'b001, 32'd9, 32'd9, 5'd14);
        tick();
        in_valid = 1'b0;
        chk("ar_post_r", out_result, 32'd81);
        chk("ar_post_d", 32'(out_dest), 32'd14);
        tick();
        exp_cnt++;
        chk("ar_post_cnt", done_cnt, 32'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
